lpif_rx_stb_align: RTL and testbench

Receive-side strobe checker and alignment gate for one LPIF-over-AIB channel. It watches the auto-inserted strobe userbit in each 80-bit received PHY word and locks once strobes arrive at the configured period. It then qualifies received data with a valid flag, counts strobe errors while locked, and drops lock after repeated misses. It sits between a channel's rx_phy word and the concat/unpack logic, as the far-end counterpart of the transmit auto-strobe insertion.

---
 rtl/lpif_rx_align_pkg.sv | 32 +++
 rtl/lpif_rx_stb_align.sv | 163 ++++++++++++++++
 tb/tb_lpif_rx_stb_align.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/lpif_rx_align_pkg.sv
// Shared types for the LPIF-over-AIB receive strobe aligner: FSM state encoding,
// debug-status field layout and small counter helpers.
package lpif_rx_align_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_CHECK  = 2'd2,
      ST_LOCKED = 2'd3
   } state_e;

   localparam int DBG_STATE_LSB  = 0;
   localparam int DBG_STATE_W    = 2;
   localparam int DBG_MISS_LSB   = 2;
   localparam int DBG_MISS_W     = 2;
   localparam int DBG_GOOD_LSB   = 4;
   localparam int DBG_GOOD_W     = 4;
   localparam int DBG_ERR_LSB    = 8;
   localparam int DBG_ERR_W      = 8;
   localparam int DBG_PERIOD_LSB = 16;
   localparam int DBG_PERIOD_W   = 8;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : (v + 8'd1);
   endfunction

   // A programmed period of zero behaves as a strobe every cycle.
   function automatic logic [7:0] eff_period(input logic [7:0] p);
      return (p == 8'd0) ? 8'd1 : p;
   endfunction

endpackage

// File: rtl/lpif_rx_stb_align.sv
// Receive strobe checker and alignment gate: locks onto the periodic strobe userbit,
// qualifies rx words while locked and counts strobe errors.
module lpif_rx_stb_align
   import lpif_rx_align_pkg::*;
#(
   parameter int WORD_W   = 80,
   parameter int STB_BIT  = 1,
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 2
) (
   input  logic              clk_wr,
   input  logic              rst_wr,
   input  logic              rx_online,
   input  logic              m_gen2_mode,
   input  logic [7:0]        stb_period,
   input  logic [WORD_W-1:0] rx_phy,
   output logic [WORD_W-1:0] rx_data,
   output logic              rx_data_valid,
   output logic              rx_aligned,
   output logic [7:0]        rx_stb_err_cnt,
   output logic [31:0]       rx_debug_status
);

   localparam int         HALF_W   = WORD_W / 2;
   localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);
   localparam logic [1:0] LOSS_TGT = 2'(LOSS_CNT);

   state_e            state_q, state_d;
   logic [7:0]        p_q, p_d;
   logic [7:0]        period_cnt_q, period_cnt_d;
   logic [3:0]        good_cnt_q, good_cnt_d;
   logic [1:0]        miss_cnt_q, miss_cnt_d;
   logic [7:0]        err_cnt_q, err_cnt_d;
   logic [WORD_W-1:0] rx_data_q, rx_data_d;
   logic              valid_q, valid_d;

   logic              s_s;
   logic              slot_s;
   logic              good_s;
   logic              bad_s;
   logic [31:0]       dbg_s;

   // Strobe event decode, lock FSM next state and counter updates.
   always_comb begin
      s_s    = rx_phy[STB_BIT];
      slot_s = (period_cnt_q == 8'd0);
      good_s = s_s & slot_s;
      bad_s  = s_s ^ slot_s;

      state_d      = state_q;
      p_d          = p_q;
      good_cnt_d   = good_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      err_cnt_d    = err_cnt_q;
      // Free-running phase: reload at the slot, otherwise count down.
      period_cnt_d = slot_s ? (p_q - 8'd1) : (period_cnt_q - 8'd1);

      if (!rx_online) begin
         state_d      = ST_IDLE;
         good_cnt_d   = 4'd0;
         miss_cnt_d   = 2'd0;
         period_cnt_d = 8'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d      = ST_SEARCH;
               p_d          = eff_period(stb_period);
               good_cnt_d   = 4'd0;
               miss_cnt_d   = 2'd0;
               period_cnt_d = 8'd0;
            end
            ST_SEARCH: begin
               if (s_s) begin
                  state_d      = ST_CHECK;
                  good_cnt_d   = 4'd1;
                  period_cnt_d = p_q - 8'd1;
               end else begin
                  good_cnt_d = 4'd0;
               end
            end
            ST_CHECK: begin
               if (good_s) begin
                  good_cnt_d = good_cnt_q + 4'd1;
                  if ((good_cnt_q + 4'd1) == LOCK_TGT) begin
                     state_d    = ST_LOCKED;
                     miss_cnt_d = 2'd0;
                  end else begin
                     state_d = ST_CHECK;
                  end
               end else if (bad_s) begin
                  // An out-of-slot strobe here is consumed by the abort, not re-used.
                  state_d    = ST_SEARCH;
                  good_cnt_d = 4'd0;
               end else begin
                  state_d = ST_CHECK;
               end
            end
            ST_LOCKED: begin
               if (bad_s) begin
                  err_cnt_d = sat_inc8(err_cnt_q);
                  if ((miss_cnt_q + 2'd1) == LOSS_TGT) begin
                     state_d    = ST_SEARCH;
                     good_cnt_d = 4'd0;
                     miss_cnt_d = 2'd0;
                  end else begin
                     miss_cnt_d = miss_cnt_q + 2'd1;
                  end
               end else if (good_s) begin
                  miss_cnt_d = 2'd0;
               end else begin
                  miss_cnt_d = miss_cnt_q;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      valid_d   = (state_q == ST_LOCKED) && rx_online;
      rx_data_d = m_gen2_mode ? rx_phy : {{(WORD_W - HALF_W){1'b0}}, rx_phy[HALF_W-1:0]};
   end

   // Debug status word assembled from the live registers.
   always_comb begin
      dbg_s = 32'h0000_0000;
      dbg_s[DBG_STATE_LSB  +: DBG_STATE_W]  = state_q;
      dbg_s[DBG_MISS_LSB   +: DBG_MISS_W]   = miss_cnt_q;
      dbg_s[DBG_GOOD_LSB   +: DBG_GOOD_W]   = good_cnt_q;
      dbg_s[DBG_ERR_LSB    +: DBG_ERR_W]    = err_cnt_q;
      dbg_s[DBG_PERIOD_LSB +: DBG_PERIOD_W] = period_cnt_q;
   end

   // State, counter and output registers.
   always_ff @(posedge clk_wr) begin
      if (rst_wr) begin
         state_q      <= ST_IDLE;
         p_q          <= 8'd1;
         period_cnt_q <= 8'd0;
         good_cnt_q   <= 4'd0;
         miss_cnt_q   <= 2'd0;
         err_cnt_q    <= 8'd0;
         rx_data_q    <= '0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         p_q          <= p_d;
         period_cnt_q <= period_cnt_d;
         good_cnt_q   <= good_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
         err_cnt_q    <= err_cnt_d;
         rx_data_q    <= rx_data_d;
         valid_q      <= valid_d;
      end
   end

   assign rx_data         = rx_data_q;
   assign rx_data_valid   = valid_q;
   assign rx_aligned      = (state_q == ST_LOCKED);
   assign rx_stb_err_cnt  = err_cnt_q;
   assign rx_debug_status = dbg_s;

endmodule

// File: tb/tb_lpif_rx_stb_align.sv
// Directed bench for lpif_rx_stb_align: hand-timed strobe patterns, point checks
// on lock/error status and a scoreboard of the qualified data words.
module tb_lpif_rx_stb_align;

   localparam int WORD_W  = 80;
   localparam int STB_BIT = 1;

   logic              clk_wr = 1'b0;
   logic              rst_wr;
   logic              rx_online;
   logic              m_gen2_mode;
   logic [7:0]        stb_period;
   logic [WORD_W-1:0] rx_phy;
   logic [WORD_W-1:0] rx_data;
   logic              rx_data_valid;
   logic              rx_aligned;
   logic [7:0]        rx_stb_err_cnt;
   logic [31:0]       rx_debug_status;

   lpif_rx_stb_align #(.WORD_W(WORD_W), .STB_BIT(STB_BIT), .LOCK_CNT(4), .LOSS_CNT(2)) dut (
      .clk_wr          (clk_wr),
      .rst_wr          (rst_wr),
      .rx_online       (rx_online),
      .m_gen2_mode     (m_gen2_mode),
      .stb_period      (stb_period),
      .rx_phy          (rx_phy),
      .rx_data         (rx_data),
      .rx_data_valid   (rx_data_valid),
      .rx_aligned      (rx_aligned),
      .rx_stb_err_cnt  (rx_stb_err_cnt),
      .rx_debug_status (rx_debug_status)
   );

   always #5 clk_wr = ~clk_wr;

   int                n_total = 0;
   int                n_pass  = 0;
   int                cyc;
   int                on_from;
   int                off_at;
   int                rst_at;
   bit                exp_locked;
   bit                stb_map [0:1023];
   logic [WORD_W-1:0] exp_q [$];
   logic [WORD_W-1:0] last_w;

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
   endtask

   // Scoreboard monitor: every qualified word must match the next expected one.
   always @(negedge clk_wr) begin
      if (rx_data_valid === 1'b1) begin
         if (exp_q.size() == 0) chk("unexpected_valid", 80'd1, 80'd0);
         else chk("sb_data", rx_data, exp_q.pop_front());
      end
   end

   task automatic step();
      logic [WORD_W-1:0] w;
      w = {16'(cyc) ^ 16'hA5C3, 32'(cyc) * 32'h9E37_79B9, 32'hC0DE_0000 | 32'(cyc)};
      w[STB_BIT] = stb_map[cyc];
      rx_phy     = w;
      rx_online  = (cyc >= on_from) && (cyc < off_at);
      rst_wr     = (cyc == rst_at);
      last_w     = m_gen2_mode ? w : {40'h0, w[39:0]};
      if (exp_locked && rx_online && !rst_wr) exp_q.push_back(last_w);
      @(posedge clk_wr);
      #1;
      cyc++;
   endtask

   task automatic play(input int last);
      while (cyc <= last) step();
   endtask

   task automatic do_reset(input logic [7:0] per, input logic g2, input int on);
      rst_wr      = 1'b1;
      rx_online   = 1'b0;
      rx_phy      = '0;
      stb_period  = per;
      m_gen2_mode = g2;
      exp_locked  = 1'b0;
      on_from     = on;
      off_at      = 100000;
      rst_at      = -1;
      for (int i = 0; i < 1024; i++) stb_map[i] = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk_wr);
      #1;
      rst_wr = 1'b0;
      cyc    = 0;
   endtask

   initial begin
      // Basic lock at P=4, early strobe while locked, then online drop.
      do_reset(8'd4, 1'b1, 5);
      chk("rst_aligned", 80'(rx_aligned), 80'd0);
      chk("rst_valid", 80'(rx_data_valid), 80'd0);
      chk("rst_err", 80'(rx_stb_err_cnt), 80'd0);
      chk("rst_debug", 80'(rx_debug_status), 80'd0);
      chk("rst_data", rx_data, 80'd0);
      stb_map[10] = 1'b1; stb_map[14] = 1'b1; stb_map[18] = 1'b1; stb_map[22] = 1'b1;
      stb_map[24] = 1'b1; stb_map[26] = 1'b1;
      off_at = 28;
      play(5);
      chk("a_search", 80'(rx_debug_status[1:0]), 80'd1);
      play(21);
      chk("a_pre_aligned", 80'(rx_aligned), 80'd0);
      chk("a_check_good3", 80'(rx_debug_status[7:0]), 80'h32);
      play(22);
      chk("a_aligned", 80'(rx_aligned), 80'd1);
      chk("a_err0", 80'(rx_stb_err_cnt), 80'd0);
      exp_locked = 1'b1;
      play(23);
      chk("a_valid", 80'(rx_data_valid), 80'd1);
      play(24);
      chk("a_early_err", 80'(rx_stb_err_cnt), 80'd1);
      chk("a_early_miss", 80'(rx_debug_status[3:2]), 80'd1);
      chk("a_early_phase", 80'(rx_debug_status[23:16]), 80'd1);
      chk("a_early_aligned", 80'(rx_aligned), 80'd1);
      play(26);
      chk("a_miss_clr", 80'(rx_debug_status[3:2]), 80'd0);
      chk("a_phase_reload", 80'(rx_debug_status[23:16]), 80'd3);
      chk("a_hold_aligned", 80'(rx_aligned), 80'd1);
      play(28);
      exp_locked = 1'b0;
      chk("a_drop_aligned", 80'(rx_aligned), 80'd0);
      chk("a_drop_valid", 80'(rx_data_valid), 80'd0);
      chk("a_drop_err_kept", 80'(rx_stb_err_cnt), 80'd1);
      chk("a_drop_idle", 80'(rx_debug_status[1:0]), 80'd0);
      play(30);
      chk("a_sb_empty", 80'(exp_q.size()), 80'd0);

      // CHECK abort on an early strobe, which is not re-used as a first strobe.
      do_reset(8'd4, 1'b1, 5);
      stb_map[10] = 1'b1; stb_map[14] = 1'b1; stb_map[15] = 1'b1; stb_map[18] = 1'b1;
      stb_map[22] = 1'b1; stb_map[26] = 1'b1; stb_map[30] = 1'b1;
      play(14);
      chk("b_check_good2", 80'(rx_debug_status[7:0]), 80'h22);
      play(15);
      chk("b_abort_search", 80'(rx_debug_status[7:0]), 80'h01);
      play(18);
      chk("b_restart", 80'(rx_debug_status[7:0]), 80'h12);
      play(29);
      chk("b_pre_aligned", 80'(rx_aligned), 80'd0);
      play(30);
      chk("b_aligned", 80'(rx_aligned), 80'd1);

      // Lock loss after two consecutive missed slots.
      do_reset(8'd4, 1'b1, 5);
      stb_map[10] = 1'b1; stb_map[14] = 1'b1; stb_map[18] = 1'b1; stb_map[22] = 1'b1;
      stb_map[26] = 1'b1;
      play(22);
      exp_locked = 1'b1;
      play(30);
      chk("c_miss1_err", 80'(rx_stb_err_cnt), 80'd1);
      chk("c_miss1_aligned", 80'(rx_aligned), 80'd1);
      play(34);
      exp_locked = 1'b0;
      chk("c_miss2_err", 80'(rx_stb_err_cnt), 80'd2);
      chk("c_loss_aligned", 80'(rx_aligned), 80'd0);
      chk("c_loss_search", 80'(rx_debug_status[1:0]), 80'd1);
      chk("c_last_valid", 80'(rx_data_valid), 80'd1);
      play(35);
      chk("c_valid_off", 80'(rx_data_valid), 80'd0);
      chk("c_sb_empty", 80'(exp_q.size()), 80'd0);

      // P=0 in gen1 mode, error saturation, lock loss at 255, reset mid-lock.
      do_reset(8'd0, 1'b0, 2);
      for (int i = 0; i < 1024; i++) stb_map[i] = 1'b1;
      for (int i = 13; i <= 612; i++) stb_map[i] = (i % 2 == 0);
      stb_map[613] = 1'b0;
      stb_map[614] = 1'b0;
      play(5);
      chk("d_pre_aligned", 80'(rx_aligned), 80'd0);
      play(6);
      chk("d_aligned", 80'(rx_aligned), 80'd1);
      exp_locked = 1'b1;
      play(12);
      chk("d_gen1_data", rx_data, last_w);
      chk("d_gen1_upper", 80'(rx_data[79:40]), 80'd0);
      play(519);
      chk("d_err254", 80'(rx_stb_err_cnt), 80'd254);
      play(521);
      chk("d_err255", 80'(rx_stb_err_cnt), 80'd255);
      play(612);
      chk("d_err_sat", 80'(rx_stb_err_cnt), 80'd255);
      chk("d_sat_aligned", 80'(rx_aligned), 80'd1);
      play(614);
      exp_locked = 1'b0;
      chk("d_sat_loss", 80'(rx_aligned), 80'd0);
      chk("d_sat_loss_err", 80'(rx_stb_err_cnt), 80'd255);
      play(618);
      chk("d_relock", 80'(rx_aligned), 80'd1);
      exp_locked = 1'b1;
      play(620);
      rst_at = 621;
      play(621);
      exp_locked = 1'b0;
      chk("d_rst_aligned", 80'(rx_aligned), 80'd0);
      chk("d_rst_valid", 80'(rx_data_valid), 80'd0);
      chk("d_rst_err", 80'(rx_stb_err_cnt), 80'd0);
      chk("d_rst_debug", 80'(rx_debug_status), 80'd0);
      chk("d_rst_data", rx_data, 80'd0);
      play(623);
      chk("d_sb_empty", 80'(exp_q.size()), 80'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
